// File: rtl/pc_branch_if.sv
// Control-flow request/response bundle between the instruction sequencer and pc_branch_unit,
// including the CON FF strobe/result pair.
interface pc_branch_if;
  logic        fetch;
  logic        start;
  logic [31:0] ir;
  logic [31:0] ra_val;
  logic        con_q;
  logic        con_in;
  logic [31:0] pc_out;
  logic [31:0] link_out;
  logic        link_we;
  logic        busy;
  logic        done;
  logic        taken;

  modport master (
    output fetch, start, ir, ra_val, con_q,
    input  con_in, pc_out, link_out, link_we, busy, done, taken
  );

  modport slave (
    input  fetch, start, ir, ra_val, con_q,
    output con_in, pc_out, link_out, link_we, busy, done, taken
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Program-counter owner and branch/jump sequencer: increments PC on fetch, resolves br through
// the CON FF, and redirects PC for jr/jal (jal also emits a link write).
module pc_branch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [4:0]  OP_BR    = 5'b10011,
  parameter logic [4:0]  OP_JR    = 5'b10100,
  parameter logic [4:0]  OP_JAL   = 5'b10101,
  parameter int unsigned CON_WAIT = 2
) (
  input logic        clk,
  input logic        rst_n,
  pc_branch_if.slave bus
);

  localparam logic [2:0] CNT_INIT = 3'(CON_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_CON,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t      state, next_state;

  logic [4:0]  op_q;
  logic [18:0] c2_q;
  logic [31:0] ra_q;
  logic [31:0] pc_q;
  logic [31:0] link_q;
  logic [2:0]  cnt_q;
  logic        link_we_q, taken_q;
  logic        con_in_q, done_q, busy_q;
  logic        con_in_d, done_d, busy_d;
  logic [31:0] br_offset;

  assign br_offset = {{13{c2_q[18]}}, c2_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:   if (bus.start) next_state = S_DECODE;
      S_DECODE: begin
        if (op_q == OP_BR)                          next_state = S_CON;
        else if (op_q == OP_JR || op_q == OP_JAL)   next_state = S_UPDATE;
        else                                        next_state = S_DONE;
      end
      S_CON:    next_state = S_WAIT;
      S_WAIT:   if (cnt_q <= 3'd1) next_state = S_UPDATE;
      S_UPDATE: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode on next_state so the registered strobes line up with the state they belong to
  always_comb begin
    con_in_d = (next_state == S_CON);
    done_d   = (next_state == S_DONE);
    busy_d   = (next_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= PC_RESET;
      link_q    <= '0;
      link_we_q <= 1'b0;
      taken_q   <= 1'b0;
      op_q      <= '0;
      c2_q      <= '0;
      ra_q      <= '0;
      cnt_q     <= '0;
      con_in_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      con_in_q  <= con_in_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      link_we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // fetch and start may coincide: the increment lands first, a later target builds on it
          if (bus.fetch) pc_q <= pc_q + 32'd1;
          if (bus.start) begin
            op_q    <= bus.ir[31:27];
            c2_q    <= bus.ir[18:0];
            ra_q    <= bus.ra_val;
            taken_q <= 1'b0;
          end
        end
        S_CON:  cnt_q <= CNT_INIT;
        S_WAIT: cnt_q <= cnt_q - 3'd1;
        S_UPDATE: begin
          if (op_q == OP_BR) begin
            if (bus.con_q) pc_q <= pc_q + br_offset;
            taken_q <= bus.con_q;
          end else begin
            pc_q    <= ra_q;
            taken_q <= 1'b1;
            if (op_q == OP_JAL) begin
              link_q    <= pc_q;
              link_we_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.con_in   = con_in_q;
  assign bus.pc_out   = pc_q;
  assign bus.link_out = link_q;
  assign bus.link_we  = link_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.taken    = taken_q;

endmodule
